xpe_stream: RTL

// Parametrised, back-pressured post-processing element; next generation of the NPU core output stage.

---
 rtl/xpe_stream.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/xpe_stream.sv
// Back-pressured NPU output stage: per-lane bias add, requantise (shift/round/saturate) and activation.
// Three registered stages share one advance enable; the bias table is read at the accept-cycle group index.
module xpe_stream #(
  parameter int LANES  = 32,
  parameter int IN_W   = 16,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_grp_last,
  input  logic                      i_bias_en,
  input  logic [4:0]                i_shift,
  input  logic [1:0]                i_act_mode,
  input  logic [OUT_W-1:0]          i_clamp_max,
  input  logic [2:0]                i_leaky_shift,
  input  logic                      i_bias_we,
  input  logic [ADDR_W-1:0]         i_bias_waddr,
  input  logic [LANES*BIAS_W-1:0]   i_bias_wdata,
  input  logic [LANES*IN_W-1:0]     i_dat,
  input  logic                      i_dat_vld,
  output logic                      o_dat_rdy,
  output logic [LANES*OUT_W-1:0]    o_dat,
  output logic                      o_dat_vld,
  input  logic                      i_dat_rdy,
  output logic [ADDR_W-1:0]         o_grp_idx,
  output logic                      o_busy
);

  localparam int SW = IN_W + 1;
  localparam int RW = IN_W + 2;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(1 << (OUT_W - 1)));

  logic [LANES*BIAS_W-1:0] bias_mem [DEPTH];
  logic [LANES*BIAS_W-1:0] bias_row;

  logic              adv;
  logic              accept;
  logic [ADDR_W-1:0] grp_q, grp_d;

  logic                   s1_vld_q, s2_vld_q, s3_vld_q;
  logic [ADDR_W-1:0]      s1_grp_q, s2_grp_q, s3_grp_q;
  logic [LANES*SW-1:0]    s1_sum_q, s1_sum_d;
  logic [LANES*OUT_W-1:0] s2_sat_q, s2_sat_d;
  logic [LANES*OUT_W-1:0] s3_dat_q, s3_dat_d;
  logic signed [OUT_W-1:0] clamp_max;

  assign adv       = !s3_vld_q || i_dat_rdy;
  assign accept    = i_dat_vld && adv;
  assign o_dat_rdy = adv;
  assign o_dat     = s3_dat_q;
  assign o_dat_vld = s3_vld_q;
  assign o_grp_idx = s3_grp_q;
  assign o_busy    = s1_vld_q || s2_vld_q || s3_vld_q;
  assign clamp_max = i_clamp_max;

  // Unregistered read: a same-cycle write lands at the edge, so the beat sees the old row.
  always_ff @(posedge i_clk) begin
    if (i_bias_we) begin
      bias_mem[i_bias_waddr] <= i_bias_wdata;
    end
  end
  assign bias_row = bias_mem[grp_q];

  always_comb begin
    grp_d = grp_q;
    if (i_start) begin
      grp_d = '0;
    end else if (accept) begin
      grp_d = (grp_q == i_grp_last) ? '0 : grp_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [IN_W-1:0]   x;
    logic signed [BIAS_W-1:0] b;
    logic signed [SW-1:0]     s_in;
    logic signed [SW-1:0]     s_st2;
    logic signed [RW-1:0]     s_ext;
    logic signed [RW-1:0]     rnd;
    logic signed [RW-1:0]     r;
    logic signed [OUT_W-1:0]  q;
    logic signed [OUT_W-1:0]  q_st3;
    logic signed [OUT_W-1:0]  a;

    assign x    = i_dat[gi*IN_W +: IN_W];
    assign b    = bias_row[gi*BIAS_W +: BIAS_W];
    assign s_in = SW'(x) + (i_bias_en ? SW'(b) : SW'(0));
    assign s1_sum_d[gi*SW +: SW] = s_in;

    // Two guard bits keep the rounding add from overflowing before the shift.
    assign s_st2 = s1_sum_q[gi*SW +: SW];
    assign s_ext = RW'(s_st2);
    assign rnd   = (i_shift == 5'd0) ? RW'(0) : (RW'(1) << (i_shift - 5'd1));
    assign r     = (s_ext + rnd) >>> i_shift;
    assign q     = (r > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                   (r < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : r[OUT_W-1:0];
    assign s2_sat_d[gi*OUT_W +: OUT_W] = q;

    assign q_st3 = s2_sat_q[gi*OUT_W +: OUT_W];
    always_comb begin
      a = q_st3;
      case (i_act_mode)
        2'd1: if (q_st3 < 0) a = '0;
        2'd2: begin
          if (q_st3 < 0) begin
            a = '0;
          end else if (q_st3 > clamp_max) begin
            a = clamp_max;
          end
        end
        2'd3: if (q_st3 < 0) a = q_st3 >>> i_leaky_shift;
        default: a = q_st3;
      endcase
    end
    assign s3_dat_d[gi*OUT_W +: OUT_W] = a;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      grp_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_grp_q <= '0;
      s2_grp_q <= '0;
      s3_grp_q <= '0;
      s1_sum_q <= '0;
      s2_sat_q <= '0;
      s3_dat_q <= '0;
    end else begin
      grp_q <= grp_d;
      if (adv) begin
        s1_vld_q <= accept;
        s1_grp_q <= grp_q;
        s1_sum_q <= s1_sum_d;
        s2_vld_q <= s1_vld_q;
        s2_grp_q <= s1_grp_q;
        s2_sat_q <= s2_sat_d;
        s3_vld_q <= s2_vld_q;
        s3_grp_q <= s2_grp_q;
        s3_dat_q <= s3_dat_d;
      end
    end
  end

endmodule
